serial_adder: RTL and testbench

//   Bit-serial WIDTH-bit adder built around one full_adder bit cell and a registered carry.
//   It accepts two parallel operands and a carry-in, then feeds one bit pair per clock, LSB first, into full_adder.
//   It shifts the sum bits into a result register and reports the parallel result plus carry-out with a done pulse.

---
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full_adder cell reused LSB-first with a registered carry.
// Result and done pulse WIDTH+1 cycles after an accepted start; start is ignored (not queued) while busy.

module full_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  output logic s_o,
  output logic co_o
);
  assign s_o  = a_i ^ b_i ^ ci_i;
  assign co_o = (a_i & b_i) | (ci_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_sh_q, res_sh_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic fa_s, fa_co;

  full_adder u_fa (
    .a_i  (a_sh_q[0]),
    .b_i  (b_sh_q[0]),
    .ci_i (carry_q),
    .s_o  (fa_s),
    .co_o (fa_co)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    cout_d   = cout_q;

    case (state_q)
      IDLE, DONE: begin
        // DONE accepts a new start just like IDLE so back-to-back runs lose only one cycle
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        carry_d  = fa_co;
        res_sh_d = {fa_s, res_sh_q[WIDTH-1:1]};
        a_sh_d   = a_sh_q >> 1;
        b_sh_d   = b_sh_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          sum_d   = {fa_s, res_sh_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder (WIDTH=8): directed table, multi-cycle corner cases, random vs. arithmetic model.

module tb_serial_adder;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         cout;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] s;
    logic         c;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One addition from a start pulse; returns the result, edges to done, and busy cycle count.
  task automatic do_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic cv,
                        output logic [W-1:0] s, output logic c, output int lat, output int busy_cnt);
    int n;
    start = 1'b1; a = av; b = bv; cin = cv;
    tick();
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    n = 0;
    busy_cnt = 0;
    while (!done && n < 20) begin
      if (busy) busy_cnt++;
      tick();
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      n++;
    end
    check("busy_done_excl", {31'b0, busy & done}, 32'd0);
    lat = n;
    s = sum;
    c = cout;
  endtask

  initial begin
    logic [W-1:0] rs;
    logic         rc;
    int           lat, bc, dcnt, prev, ndone;
    logic [W:0]   model;

    vecs[0] = '{a: 8'h0F, b: 8'h01, cin: 1'b0, s: 8'h10, c: 1'b0};
    vecs[1] = '{a: 8'hFF, b: 8'h01, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[2] = '{a: 8'hFF, b: 8'hFF, cin: 1'b1, s: 8'hFF, c: 1'b1};
    vecs[3] = '{a: 8'h12, b: 8'h34, cin: 1'b0, s: 8'h46, c: 1'b0};
    vecs[4] = '{a: 8'h80, b: 8'h80, cin: 1'b0, s: 8'h00, c: 1'b1};
    vecs[5] = '{a: 8'hAA, b: 8'h55, cin: 1'b0, s: 8'hFF, c: 1'b0};
    vecs[6] = '{a: 8'h7F, b: 8'h01, cin: 1'b1, s: 8'h81, c: 1'b0};
    vecs[7] = '{a: 8'h00, b: 8'h00, cin: 1'b1, s: 8'h01, c: 1'b0};

    // Reset held two edges with start asserted
    rst = 1'b1; start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b1;
    tick();
    tick();
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_done", {31'b0, done}, 32'd0);
    check("rst_sum", {24'b0, sum}, 32'h00);
    check("rst_cout", {31'b0, cout}, 32'd0);
    start = 1'b0;
    rst = 1'b0;
    tick();
    check("post_rst_busy", {31'b0, busy}, 32'd0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      do_add(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bc);
      check($sformatf("tbl%0d_sum", i), {24'b0, rs}, {24'b0, vecs[i].s});
      check($sformatf("tbl%0d_cout", i), {31'b0, rc}, {31'b0, vecs[i].c});
      check($sformatf("tbl%0d_lat", i), lat, 32'd8);
      check($sformatf("tbl%0d_busy", i), bc, 32'd8);
      tick();
      check($sformatf("tbl%0d_done_pulse", i), {31'b0, done}, 32'd0);
    end

    // Start while busy is ignored
    start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
    tick();
    start = 1'b0;
    tick();
    tick();
    start = 1'b1; a = 8'hAA; b = 8'h55;
    tick();
    start = 1'b0;
    dcnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (done) begin
        dcnt++;
        check("ign_sum", {24'b0, sum}, 32'h46);
        check("ign_cout", {31'b0, cout}, 32'd0);
      end
      tick();
    end
    check("ign_done_count", dcnt, 32'd1);

    // Reset in the middle of RUN
    start = 1'b1; a = 8'h80; b = 8'h80; cin = 1'b0;
    tick();
    start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("mid_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", {31'b0, busy}, 32'd0);
    check("mid_sum", {24'b0, sum}, 32'h00);
    check("mid_cout", {31'b0, cout}, 32'd0);
    dcnt = 0;
    for (int i = 0; i < 12; i++) begin
      if (done) dcnt++;
      tick();
    end
    check("mid_no_done", dcnt, 32'd0);

    // Start held high: one result every WIDTH+1 cycles
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0;
    prev = -1;
    ndone = 0;
    for (int i = 0; i < 45; i++) begin
      tick();
      if (done) begin
        ndone++;
        check("b2b_sum", {24'b0, sum}, 32'h02);
        check("b2b_cout", {31'b0, cout}, 32'd0);
        if (prev >= 0) check("b2b_period", i - prev, 32'd9);
        prev = i;
      end
    end
    check("b2b_count", ndone, 32'd5);
    start = 1'b0;
    tick();
    tick();

    // Random operands against plain arithmetic
    for (int i = 0; i < 40; i++) begin
      logic [W-1:0] ra, rb;
      logic         rci;
      ra  = W'($urandom);
      rb  = W'($urandom);
      rci = 1'($urandom);
      model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rci};
      do_add(ra, rb, rci, rs, rc, lat, bc);
      check("rnd_sum", {24'b0, rs}, {24'b0, model[W-1:0]});
      check("rnd_cout", {31'b0, rc}, {31'b0, model[W]});
      check("rnd_lat", lat, 32'd8);
      if ((i % 3) == 0) tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
